// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DVD_W = 16;
  localparam int unsigned DVS_W = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [DVD_W-1:0] DBZ_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_16x8_if.sv
// Start/busy/done handshake and operand/result bus for seq_divider_16x8.
interface seq_divider_16x8_if;

  logic                        start;
  logic [div_pkg::DVD_W-1:0]   dividend;
  logic [div_pkg::DVS_W-1:0]   divisor;
  logic                        busy;
  logic                        done;
  logic [div_pkg::DVD_W-1:0]   quotient;
  logic [div_pkg::DVS_W-1:0]   remainder;
  logic                        dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );

endinterface

// File: rtl/sub_ripple9.sv
// 9-bit ripple-borrow subtractor (diff = a - b) built from 1-bit full-subtractor cells.
module sub_ripple9 (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] diff,
  output logic       borrow_out
);

  logic [9:0] bw;

  assign bw[0] = 1'b0;

  for (genvar i = 0; i < 9; i++) begin : g_cell
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign borrow_out = bw[9];

endmodule

// File: rtl/seq_divider_16x8.sv
// Sequential restoring divider, 16-bit dividend / 8-bit divisor, one quotient bit per clock.
module seq_divider_16x8
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  seq_divider_16x8_if.slave   bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DVD_W-1:0]   shreg_q, shreg_d;
  logic [DVS_W-1:0]   rem_q, rem_d;
  logic [DVS_W-1:0]   dvs_q, dvs_d;
  logic [DVD_W-1:0]   quotient_q, quotient_d;
  logic [DVS_W-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic [DVS_W:0]     partial, diff;
  logic               borrow;
  logic [DVS_W-1:0]   rem_next;
  logic [DVD_W-1:0]   shreg_next;
  logic               unused_diff_msb;

  // Shift register carries the remaining dividend bits out of the MSB and quotient bits in at the LSB.
  assign partial = {rem_q, shreg_q[DVD_W-1]};

  sub_ripple9 u_sub (
    .a          (partial),
    .b          ({1'b0, dvs_q}),
    .diff       (diff),
    .borrow_out (borrow)
  );

  // rem < divisor keeps a non-borrowing difference below 256, so bit 8 is always zero.
  assign unused_diff_msb = diff[DVS_W];
  assign rem_next        = borrow ? partial[DVS_W-1:0] : diff[DVS_W-1:0];
  assign shreg_next      = {shreg_q[DVD_W-2:0], ~borrow};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            state_d = StRun;
            shreg_d = bus.dividend;
            dvs_d   = bus.divisor;
            rem_d   = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
          end else begin
            state_d     = StDone;
            quotient_d  = DBZ_QUOT;
            remainder_d = bus.dividend[DVS_W-1:0];
            dbz_d       = 1'b1;
          end
        end
      end
      StRun: begin
        shreg_d = shreg_next;
        rem_d   = rem_next;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DVD_W - 1)) begin
          state_d     = StDone;
          quotient_d  = shreg_next;
          remainder_d = rem_next;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shreg_q     <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.dbz       = dbz_q;

endmodule
